alu_result_register: RTL and testbench
======================================

// Module: alu_result_register
// PURPOSE
//  Adder hold register (ADD) on the ALU output side; complements the ALU A/B input registers.
//  Captures the ALU sum and flags on a latch strobe, with optional BCD correction (DAA/DSA).
//  Holds the value between strobes and drives it back onto the special bus (SB) and the
//  low address bus (ADL) under independent drive controls (nets add_sb_0_6, add_sb_7, add_adl).
// PARAMETERS
//  WIDTH      8  data width; only 8 is supported
//  DECIMAL_EN 1  1 = daa/dsa correction enabled; 0 = daa/dsa are ignored (binary only)
// PORTS
//  clk            in   1  system clock; the capture edge
//  reset_n        in   1  asynchronous, active-low reset
//  latch          in   1  capture ALU outputs at the next rising clk
//  alu_result     in   8  raw ALU sum/logic result
//  alu_carry      in   1  ALU carry out (ACR source)
//  alu_overflow   in   1  ALU overflow (AVR source)
//  alu_half_carry in   1  carry from bit 3 to bit 4 (HC)
//  daa            in   1  decimal add adjust request (sampled with latch)
//  dsa            in   1  decimal subtract adjust request (sampled with latch)
//  add_sb_0_6     in   1  drive held bits 6:0 onto SB
//  add_sb_7       in   1  drive held bit 7 onto SB
//  add_adl        in   1  drive held byte onto ADL
//  sb_out         out  8  SB data; bits with no drive enable read 0
//  sb_drive       out  8  per-bit SB drive enable: {add_sb_7, {7{add_sb_0_6}}}
//  adl_out        out  8  ADL data; reads 0 when add_adl=0
//  adl_drive      out  1  equals add_adl
//  acr            out  1  latched carry, after decimal correction
//  avr            out  1  latched overflow
//  held           out  1  1 = register contains a captured value
//  empty_read     out  1  registered pulse: a drive occurred while held=0
// BEHAVIOUR
//  Reset (async, reset_n=0): hold=0x00, acr=0, avr=0, held=0, empty_read=0.
//   Bus outputs then depend only on the drive inputs (data reads 0).
//  State: EMPTY (held=0) and HELD (held=1).
//   EMPTY -> HELD on the first latch. HELD stays HELD; each latch overwrites the value.
//   Only reset returns the block to EMPTY.
//  Capture: when latch=1 at a clk edge, hold<=adj(alu_result), acr<=adj_carry, avr<=alu_overflow.
//   Latency is 1 clock. When latch=0, hold, acr and avr keep their values.
//  Decimal correction applies only if DECIMAL_EN=1. Arithmetic is mod 256.
//   daa=1: add 0x06 if alu_half_carry=1; add 0x60 if alu_carry=1.
//     adj_carry = alu_carry.
//   dsa=1: subtract 0x06 if alu_half_carry=0; subtract 0x60 if alu_carry=0.
//     adj_carry = alu_carry.
//   daa=1 and dsa=1 together is illegal: no correction is applied, and simulation asserts an error.
//   Otherwise, adj = alu_result.
//  Drive outputs are combinational from the registered hold value and the drive inputs.
//   A latch and a drive in the same cycle drive the old value; the new value appears next cycle.
//   SB and ADL may be driven at the same time.
//  empty_read <= (add_sb_0_6 | add_sb_7 | add_adl) & ~held.
//   While EMPTY, driven data is 0x00.
//  Reset asserted mid-hold clears everything immediately, without waiting for clk.
//   The first latch after release loads normally.
// STRUCTURE
//  cpu6502_pkg holds:
//   - the state enum {EMPTY, HELD};
//   - the constants BCD_LO_ADJ=8'h06 and BCD_HI_ADJ=8'h60.
//  Sub-module bcd_adjust: combinational; (alu_result, hc, c, daa, dsa) -> (adj, adj_carry).
//  Top level holds: hold/flag registers, the state bit, the drive muxes, empty_read.
// TESTING
//  1 Reset, then add_sb_0_6=1 -> sb_out=0x00, sb_drive=0x7F, held=0, empty_read=1 next cycle.
//  2 latch with alu_result=0xC3, then add_sb_0_6=add_sb_7=1, add_adl=1
//    -> sb_out=0xC3, sb_drive=0xFF, adl_out=0xC3, held=1.
//  3 daa=1, alu_result=0x0F, hc=1, c=0 -> hold=0x15, acr=0.
//    Then daa=1, alu_result=0xA0, c=1 -> hold=0x00, acr=1.
//  4 dsa=1, alu_result=0xFF, hc=0, c=0 -> hold=0x99, acr=0.
//    With DECIMAL_EN=0, the same inputs give hold=0xFF.
//  5 hold=0x11; latch alu_result=0x22 with add_adl=1 in the same cycle
//    -> adl_out=0x11 that cycle, 0x22 the next.
//  6 hold=0x5A, held=1; pulse reset_n low between clk edges
//    -> hold=0x00, held=0, acr=avr=0 immediately.

Source files
------------

// File: rtl/cpu6502_pkg.sv
// Shared types and constants for the 6502-style datapath slice.
package cpu6502_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } hold_state_t;

  localparam logic [7:0] BCD_LO_ADJ = 8'h06;
  localparam logic [7:0] BCD_HI_ADJ = 8'h60;

endpackage

// File: rtl/bcd_adjust.sv
// Combinational decimal correction applied to the raw ALU sum before capture.
module bcd_adjust
  import cpu6502_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter bit          DECIMAL_EN = 1'b1
) (
  input  logic [WIDTH-1:0] alu_result,
  input  logic             hc,
  input  logic             c,
  input  logic             daa,
  input  logic             dsa,
  output logic [WIDTH-1:0] adj,
  output logic             adj_carry
);

  always_comb begin
    adj       = alu_result;
    adj_carry = c;
    // Requesting both adjustments at once is illegal and leaves the sum untouched.
    if (DECIMAL_EN && (daa ^ dsa)) begin
      if (daa) begin
        if (hc) adj = adj + BCD_LO_ADJ;
        if (c)  adj = adj + BCD_HI_ADJ;
      end else begin
        if (!hc) adj = adj - BCD_LO_ADJ;
        if (!c)  adj = adj - BCD_HI_ADJ;
      end
    end
  end

endmodule

// File: rtl/alu_result_register.sv
// Adder hold register: captures the (decimal-corrected) ALU result and flags,
// and drives the held byte onto SB and ADL under independent enables.
module alu_result_register
  import cpu6502_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter bit          DECIMAL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             latch,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  input  logic             alu_overflow,
  input  logic             alu_half_carry,
  input  logic             daa,
  input  logic             dsa,
  input  logic             add_sb_0_6,
  input  logic             add_sb_7,
  input  logic             add_adl,
  output logic [WIDTH-1:0] sb_out,
  output logic [WIDTH-1:0] sb_drive,
  output logic [WIDTH-1:0] adl_out,
  output logic             adl_drive,
  output logic             acr,
  output logic             avr,
  output logic             held,
  output logic             empty_read
);

  hold_state_t      state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             acr_q, acr_d;
  logic             avr_q, avr_d;
  logic             empty_read_q, empty_read_d;
  logic [WIDTH-1:0] adj;
  logic             adj_carry;
  logic             any_drive;

  bcd_adjust #(
    .WIDTH      (WIDTH),
    .DECIMAL_EN (DECIMAL_EN)
  ) u_bcd_adjust (
    .alu_result (alu_result),
    .hc         (alu_half_carry),
    .c          (alu_carry),
    .daa        (daa),
    .dsa        (dsa),
    .adj        (adj),
    .adj_carry  (adj_carry)
  );

  assign any_drive = add_sb_0_6 | add_sb_7 | add_adl;

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    acr_d        = acr_q;
    avr_d        = avr_q;
    empty_read_d = any_drive & (state_q == EMPTY);
    if (latch) begin
      state_d = HELD;
      hold_d  = adj;
      acr_d   = adj_carry;
      avr_d   = alu_overflow;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= EMPTY;
      hold_q       <= '0;
      acr_q        <= 1'b0;
      avr_q        <= 1'b0;
      empty_read_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      acr_q        <= acr_d;
      avr_q        <= avr_d;
      empty_read_q <= empty_read_d;
      if (DECIMAL_EN && latch)
        assert (!(daa && dsa)) else $error("alu_result_register: daa and dsa both set");
    end
  end

  // Hold is cleared while EMPTY, so masking by the enables alone yields 0x00 there.
  assign sb_drive   = {add_sb_7, {(WIDTH-1){add_sb_0_6}}};
  assign sb_out     = hold_q & sb_drive;
  assign adl_out    = add_adl ? hold_q : '0;
  assign adl_drive  = add_adl;
  assign acr        = acr_q;
  assign avr        = avr_q;
  assign held       = (state_q == HELD);
  assign empty_read = empty_read_q;

endmodule

// File: tb/tb_alu_result_register.sv
// Directed plus randomized checks of alu_result_register against a behavioural model.
module tb_alu_result_register;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       latch = 1'b0;
  logic [7:0] alu_result = '0;
  logic       alu_carry = 1'b0, alu_overflow = 1'b0, alu_half_carry = 1'b0;
  logic       daa = 1'b0, dsa = 1'b0;
  logic       add_sb_0_6 = 1'b0, add_sb_7 = 1'b0, add_adl = 1'b0;

  logic [7:0] sb_out, sb_drive, adl_out;
  logic       adl_drive, acr, avr, held, empty_read;
  logic [7:0] b_sb_out, b_sb_drive, b_adl_out;
  logic       b_adl_drive, b_acr, b_avr, b_held, b_empty_read;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference state
  logic [7:0] m_hold, m_hold_bin;
  logic       m_acr, m_avr, m_held, m_er;

  always #5 clk = ~clk;

  alu_result_register #(.WIDTH(8), .DECIMAL_EN(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .latch(latch), .alu_result(alu_result),
    .alu_carry(alu_carry), .alu_overflow(alu_overflow), .alu_half_carry(alu_half_carry),
    .daa(daa), .dsa(dsa), .add_sb_0_6(add_sb_0_6), .add_sb_7(add_sb_7), .add_adl(add_adl),
    .sb_out(sb_out), .sb_drive(sb_drive), .adl_out(adl_out), .adl_drive(adl_drive),
    .acr(acr), .avr(avr), .held(held), .empty_read(empty_read)
  );

  alu_result_register #(.WIDTH(8), .DECIMAL_EN(1'b0)) dut_bin (
    .clk(clk), .reset_n(reset_n), .latch(latch), .alu_result(alu_result),
    .alu_carry(alu_carry), .alu_overflow(alu_overflow), .alu_half_carry(alu_half_carry),
    .daa(daa), .dsa(dsa), .add_sb_0_6(add_sb_0_6), .add_sb_7(add_sb_7), .add_adl(add_adl),
    .sb_out(b_sb_out), .sb_drive(b_sb_drive), .adl_out(b_adl_out), .adl_drive(b_adl_drive),
    .acr(b_acr), .avr(b_avr), .held(b_held), .empty_read(b_empty_read)
  );

  function automatic logic [7:0] ref_adj(input logic [7:0] r, input logic hc, input logic c,
                                         input logic da, input logic ds, input bit dec);
    int v;
    v = int'(r);
    if (dec && !(da && ds)) begin
      if (da && hc)  v = v + 6;
      if (da && c)   v = v + 96;
      if (ds && !hc) v = v - 6;
      if (ds && !c)  v = v - 96;
    end
    return 8'(v & 255);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hold = '0; m_hold_bin = '0; m_acr = 0; m_avr = 0; m_held = 0; m_er = 0;
  endtask

  // Advance one clock and update the model with the inputs present at that edge.
  task automatic tick();
    @(posedge clk);
    if (reset_n) begin
      m_er = (add_sb_0_6 | add_sb_7 | add_adl) & ~m_held;
      if (latch) begin
        m_hold     = ref_adj(alu_result, alu_half_carry, alu_carry, daa, dsa, 1'b1);
        m_hold_bin = ref_adj(alu_result, alu_half_carry, alu_carry, daa, dsa, 1'b0);
        m_acr      = alu_carry;
        m_avr      = alu_overflow;
        m_held     = 1'b1;
      end
    end
    #1;
  endtask

  task automatic check_all(input string tag);
    logic [7:0] drv;
    #1;
    drv = {add_sb_7, {7{add_sb_0_6}}};
    chk({tag, ".sb_drive"}, sb_drive, drv);
    chk({tag, ".sb_out"}, sb_out, m_hold & drv);
    chk({tag, ".adl_out"}, adl_out, add_adl ? m_hold : 8'h00);
    chk({tag, ".adl_drive"}, {7'd0, adl_drive}, {7'd0, add_adl});
    chk({tag, ".acr"}, {7'd0, acr}, {7'd0, m_acr});
    chk({tag, ".avr"}, {7'd0, avr}, {7'd0, m_avr});
    chk({tag, ".held"}, {7'd0, held}, {7'd0, m_held});
    chk({tag, ".empty_read"}, {7'd0, empty_read}, {7'd0, m_er});
    chk({tag, ".bin_adl_out"}, b_adl_out, add_adl ? m_hold_bin : 8'h00);
    chk({tag, ".bin_held"}, {7'd0, b_held}, {7'd0, m_held});
  endtask

  task automatic set_alu(input logic [7:0] r, input logic c, input logic hc,
                         input logic v, input logic da, input logic ds);
    alu_result = r; alu_carry = c; alu_half_carry = hc; alu_overflow = v; daa = da; dsa = ds;
  endtask

  task automatic set_drv(input logic s06, input logic s7, input logic a);
    add_sb_0_6 = s06; add_sb_7 = s7; add_adl = a;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset_n = 1'b1;

    // Drive while empty: zero data, empty_read pulses next cycle
    set_drv(1, 0, 0);
    check_all("t1_drive");
    chk("t1_sb_drive_lit", sb_drive, 8'h7F);
    tick();
    check_all("t1_after");
    chk("t1_empty_read_lit", {7'd0, empty_read}, 8'h01);
    chk("t1_sb_out_lit", sb_out, 8'h00);

    // Plain capture and full drive
    set_drv(0, 0, 0);
    latch = 1; set_alu(8'hC3, 0, 0, 0, 0, 0);
    tick();
    latch = 0; set_drv(1, 1, 1);
    check_all("t2");
    chk("t2_sb_out_lit", sb_out, 8'hC3);
    chk("t2_adl_out_lit", adl_out, 8'hC3);
    chk("t2_sb_drive_lit", sb_drive, 8'hFF);
    tick();
    check_all("t2_held_no_er");

    // Decimal add adjust
    set_drv(0, 0, 1);
    latch = 1; set_alu(8'h0F, 0, 1, 0, 1, 0);
    tick();
    latch = 0;
    check_all("t3a");
    chk("t3a_lit", adl_out, 8'h15);
    latch = 1; set_alu(8'hA0, 1, 0, 1, 1, 0);
    tick();
    latch = 0;
    check_all("t3b");
    chk("t3b_lit", adl_out, 8'h00);
    chk("t3b_acr_lit", {7'd0, acr}, 8'h01);

    // Decimal subtract adjust, and binary-only instance ignores it
    latch = 1; set_alu(8'hFF, 0, 0, 0, 0, 1);
    tick();
    latch = 0;
    check_all("t4");
    chk("t4_lit", adl_out, 8'h99);
    chk("t4_bin_lit", b_adl_out, 8'hFF);

    // Latch and drive in the same cycle: old value first
    latch = 1; set_alu(8'h11, 0, 0, 0, 0, 0);
    tick();
    set_alu(8'h22, 0, 0, 0, 0, 0);
    check_all("t5_same");
    chk("t5_old_lit", adl_out, 8'h11);
    tick();
    latch = 0;
    check_all("t5_next");
    chk("t5_new_lit", adl_out, 8'h22);

    // Asynchronous reset between edges
    latch = 1; set_alu(8'h5A, 1, 0, 1, 0, 0);
    tick();
    latch = 0; set_drv(1, 1, 1);
    check_all("t6_pre");
    #2 reset_n = 1'b0;
    model_reset();
    check_all("t6_async");
    chk("t6_held_lit", {7'd0, held}, 8'h00);
    set_drv(0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    latch = 1; set_alu(8'h3C, 0, 0, 0, 0, 0);
    tick();
    latch = 0; set_drv(0, 0, 1);
    check_all("t6_reload");
    chk("t6_reload_lit", adl_out, 8'h3C);

    // Randomized traffic; daa and dsa never both requested
    for (int i = 0; i < 300; i++) begin
      logic da, ds;
      da = 1'($urandom_range(0, 1));
      ds = da ? 1'b0 : 1'($urandom_range(0, 1));
      latch = 1'($urandom_range(0, 2) == 0);
      set_alu(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), da, ds);
      set_drv(1'($urandom), 1'($urandom), 1'($urandom));
      check_all("rand");
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
